// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared constants, types and write-port priority helper for regfile_mp
// Revision : 1.0
// ============================================================================
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);
   localparam int MAX_WR    = 16;

   typedef logic [AW_DEF-1:0] reg_addr_t;

   // Highest-index set bit wins; returns 0 when nothing hits, so callers gate with |hit.
   function automatic int win_port(input logic [MAX_WR-1:0] hit);
      int sel;
      sel = 0;
      for (int i = 0; i < MAX_WR; i++) begin
         if (hit[i]) sel = i;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-register pending-write bits with set-over-clear and read masking
// Revision : 1.0
// ============================================================================
module rf_scoreboard #(
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREGS-1:0]  i_set_vec,
   input  logic [NREGS-1:0]  i_clr_vec,
   input  logic [NRD*AW-1:0] i_rs_addr,
   input  logic [NRD-1:0]    i_rs_hit,
   output logic [NRD-1:0]    o_rs_busy,
   output logic [NREGS-1:0]  o_busy_vec
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   always_comb begin
      w_busy_nxt = i_set_vec | (r_busy & ~i_clr_vec);
      if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_busy <= '0;
      else       r_busy <= w_busy_nxt;
   end

   // A write retiring this cycle already satisfies the reader through the bypass.
   for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
      assign o_rs_busy[k] = r_busy[i_rs_addr[k*AW +: AW]] & ~i_rs_hit[k];
   end

   assign o_busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with write-through bypass and scoreboard
// Revision : 1.0
// ============================================================================
module regfile_mp
   import rf_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NRD*AW-1:0]   i_rs_addr,
   output logic [NRD*XLEN-1:0] o_rs_dout,
   output logic [NRD-1:0]      o_rs_busy,
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   input  logic                i_alloc_en,
   input  logic [AW-1:0]       i_alloc_addr,
   output logic [NREGS-1:0]    o_busy_vec
);

   logic [XLEN-1:0]             r_regs [NREGS];
   logic [NREGS-1:0]            w_we;
   logic [NREGS-1:0]            w_wr_any;
   logic [NREGS-1:0]            w_alloc_vec;
   logic [NREGS-1:0][XLEN-1:0]  w_wd;
   logic [NRD-1:0][XLEN-1:0]    w_dout;
   logic [NRD-1:0]              w_rs_hit;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      logic [MAX_WR-1:0] w_hit;
      int                w_sel;

      always_comb begin
         w_hit = '0;
         for (int p = 0; p < NWR; p++) begin
            w_hit[p] = i_wr_en[p] && (i_wr_addr[p*AW +: AW] == AW'(r));
         end
      end

      assign w_sel          = win_port(w_hit);
      assign w_wr_any[r]    = |w_hit;
      assign w_we[r]        = w_wr_any[r] && !((ZERO_REG != 0) && (r == 0));
      assign w_wd[r]        = i_wr_data[w_sel*XLEN +: XLEN];
      assign w_alloc_vec[r] = i_alloc_en && (i_alloc_addr == AW'(r));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (w_we[r]) r_regs[r] <= w_wd[r];
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [MAX_WR-1:0] w_hit;
      int                w_sel;
      logic [AW-1:0]     w_a;

      assign w_a = i_rs_addr[k*AW +: AW];

      always_comb begin
         w_hit = '0;
         for (int p = 0; p < NWR; p++) begin
            w_hit[p] = i_wr_en[p] && (i_wr_addr[p*AW +: AW] == w_a);
         end
      end

      assign w_sel       = win_port(w_hit);
      assign w_rs_hit[k] = |w_hit;
      assign w_dout[k]   = ((ZERO_REG != 0) && (w_a == '0)) ? '0 :
                           (|w_hit) ? i_wr_data[w_sel*XLEN +: XLEN] : r_regs[w_a];
   end

   assign o_rs_dout = w_dout;

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_set_vec  (w_alloc_vec),
      .i_clr_vec  (w_wr_any),
      .i_rs_addr  (i_rs_addr),
      .i_rs_hit   (w_rs_hit),
      .o_rs_busy  (o_rs_busy),
      .o_busy_vec (o_busy_vec)
   );

endmodule
`default_nettype wire
